// File: rtl/crc8_frame_tx.sv
// Serial CRC-8 frame transmitter: parallel payload in, LSB-first payload bits
// out followed by the MSB-first CRC, with en/capture strobes for the checker.
module crc8_frame_tx #(
    parameter int unsigned DATA_W = 64,
    parameter logic [7:0]  POLY   = 8'h07,
    parameter logic [7:0]  INIT   = 8'h00
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              data_o,
    output logic              en_o,
    output logic              capture_o,
    output logic              busy_o
);

    localparam int unsigned FRAME_W = DATA_W + 8;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [CNT_W-1:0] LAST_PAYLOAD = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] PRE_LAST     = CNT_W'(FRAME_W - 2);
    localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CRC
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [7:0]        crc_q, crc_d, crc_step;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_d, data_d, en_d, capture_d, busy_d;
    logic              fb;

    // shift_q[0] is always the payload bit currently on data_o
    assign fb       = crc_q[7] ^ shift_q[0];
    assign crc_step = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        ready_d   = ready_o;
        data_d    = data_o;
        en_d      = en_o;
        capture_d = capture_o;
        busy_d    = busy_o;

        unique case (state_q)
            ST_IDLE: begin
                if (valid_i && ready_o) begin
                    state_d   = ST_PAYLOAD;
                    shift_d   = data_i;
                    crc_d     = INIT;
                    cnt_d     = '0;
                    data_d    = data_i[0];
                    en_d      = 1'b1;
                    capture_d = 1'b0;
                    busy_d    = 1'b1;
                    ready_d   = 1'b0;
                end
            end

            ST_PAYLOAD: begin
                crc_d   = crc_step;
                shift_d = shift_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_PAYLOAD) begin
                    state_d = ST_CRC;
                    data_d  = crc_step[7];
                end else begin
                    data_d  = shift_d[0];
                end
            end

            ST_CRC: begin
                // The finished CRC drains out of the register MSB-first.
                cnt_d  = cnt_q + CNT_W'(1);
                crc_d  = {crc_q[6:0], 1'b0};
                data_d = crc_q[6];
                if (cnt_q == PRE_LAST) begin
                    en_d      = 1'b0;
                    capture_d = 1'b1;
                end
                if (cnt_q == LAST_BIT) begin
                    state_d   = ST_IDLE;
                    crc_d     = INIT;
                    cnt_d     = '0;
                    data_d    = 1'b0;
                    en_d      = 1'b0;
                    capture_d = 1'b0;
                    busy_d    = 1'b0;
                    ready_d   = 1'b1;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                data_d    = 1'b0;
                en_d      = 1'b0;
                capture_d = 1'b0;
                busy_d    = 1'b0;
                ready_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            crc_q     <= INIT;
            cnt_q     <= '0;
            ready_o   <= 1'b1;
            data_o    <= 1'b0;
            en_o      <= 1'b0;
            capture_o <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            ready_o   <= ready_d;
            data_o    <= data_d;
            en_o      <= en_d;
            capture_o <= capture_d;
            busy_o    <= busy_d;
        end
    end

endmodule
